fibonacci_checker: RTL and testbench



---
 rtl/fibonacci_pkg.sv | 29 ++
 rtl/fibonacci_seq.sv | 51 +++++
 rtl/fibonacci_checker.sv | 122 ++++++++++++
 tb/tb_fibonacci_checker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fibonacci_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fibonacci_pkg
// Description : Shared word/length types, checker state and result record.
// Revision    : 1.0 - initial release
// ============================================================================
package fibonacci_pkg;

  localparam int unsigned C_WORD_W = 32;
  localparam int unsigned C_LEN_W  = 8;

  typedef logic [C_WORD_W-1:0] fib_word_t;
  typedef logic [C_LEN_W-1:0]  fib_len_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    REPORT = 2'd2
  } fib_state_t;

  typedef struct packed {
    logic      pass;
    fib_len_t  count;
    fib_len_t  err_idx;
    fib_word_t err_data;
  } fib_result_t;

endpackage : fibonacci_pkg
`default_nettype wire

// File: rtl/fibonacci_seq.sv
`default_nettype none
// ============================================================================
// Module      : fibonacci_seq
// Description : Expected-value generator: 0, 1, then prev+cur (mod 2^32).
// Revision    : 1.0 - initial release
// ============================================================================
module fibonacci_seq
  import fibonacci_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clear,
  input  logic      advance,
  output fib_word_t expected,
  output fib_len_t  index
);

  fib_word_t r_prev;
  fib_word_t r_cur;
  fib_len_t  r_idx;
  fib_word_t w_next;

  always_comb begin
    w_next = r_prev + r_cur;
    if (r_idx == '0)
      w_next = '0;
    else if (r_idx == fib_len_t'(1))
      w_next = fib_word_t'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
      r_cur  <= '0;
      r_idx  <= '0;
    end else if (clear) begin
      r_prev <= '0;
      r_cur  <= '0;
      r_idx  <= '0;
    end else if (advance) begin
      r_prev <= r_cur;
      r_cur  <= w_next;
      r_idx  <= r_idx + fib_len_t'(1);
    end
  end

  assign expected = w_next;
  assign index    = r_idx;

endmodule : fibonacci_seq
`default_nettype wire

// File: rtl/fibonacci_checker.sv
`default_nettype none
// ============================================================================
// Module      : fibonacci_checker
// Description : Accepts N beats, checks them against the Fibonacci sequence
//               and returns one pass/fail result beat.
// Revision    : 1.0 - initial release
// ============================================================================
module fibonacci_checker
  import fibonacci_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_len,
  output logic        cmd_ready,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        res_valid,
  output logic        res_pass,
  output logic [7:0]  res_count,
  output logic [7:0]  res_err_idx,
  output logic [31:0] res_err_data,
  input  logic        res_ready
);

  fib_state_t  r_state;
  fib_len_t    r_len;
  logic        r_fail;
  fib_len_t    r_err_idx;
  fib_word_t   r_err_data;
  fib_result_t r_result;

  fib_word_t   w_expected;
  fib_len_t    w_index;
  logic        w_cmd_hs;
  logic        w_beat_hs;
  logic        w_mismatch;
  logic        w_first_err;
  logic        w_last;
  fib_result_t w_final;

  assign w_cmd_hs    = cmd_valid & (r_state == IDLE);
  assign w_beat_hs   = in_valid & (r_state == RECV);
  assign w_mismatch  = w_beat_hs & (in_data != w_expected);
  assign w_first_err = w_mismatch & ~r_fail;
  assign w_last      = w_beat_hs & (w_index == (r_len - fib_len_t'(1)));

  // The sequencer's index doubles as the beat counter.
  fibonacci_seq u_seq (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_cmd_hs),
    .advance  (w_beat_hs),
    .expected (w_expected),
    .index    (w_index)
  );

  // The final beat may itself be the first mismatch, so fold it in here.
  always_comb begin
    w_final          = '0;
    w_final.pass     = ~(r_fail | w_mismatch);
    w_final.count    = r_len;
    w_final.err_idx  = w_first_err ? w_index : r_err_idx;
    w_final.err_data = w_first_err ? in_data : r_err_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_fail     <= 1'b0;
      r_err_idx  <= '0;
      r_err_data <= '0;
      r_result   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_len      <= cmd_len;
            r_fail     <= 1'b0;
            r_err_idx  <= '0;
            r_err_data <= '0;
            if (cmd_len == '0) begin
              r_result      <= '0;
              r_result.pass <= 1'b1;
              r_state       <= REPORT;
            end else begin
              r_state <= RECV;
            end
          end
        end
        RECV: begin
          if (w_first_err) begin
            r_fail     <= 1'b1;
            r_err_idx  <= w_index;
            r_err_data <= in_data;
          end
          if (w_last) begin
            r_result <= w_final;
            r_state  <= REPORT;
          end
        end
        REPORT: begin
          if (res_ready)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready    = (r_state == IDLE);
  assign in_ready     = (r_state == RECV);
  assign res_valid    = (r_state == REPORT);
  assign res_pass     = r_result.pass;
  assign res_count    = r_result.count;
  assign res_err_idx  = r_result.err_idx;
  assign res_err_data = r_result.err_data;

endmodule : fibonacci_checker
`default_nettype wire

// File: tb/tb_fibonacci_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_fibonacci_checker
// Description : Directed self-checking bench for fibonacci_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fibonacci_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_len = '0;
  logic        cmd_ready;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        res_valid;
  logic        res_pass;
  logic [7:0]  res_count;
  logic [7:0]  res_err_idx;
  logic [31:0] res_err_data;
  logic        res_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] vec [0:63];

  fibonacci_checker dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_len      (cmd_len),
    .cmd_ready    (cmd_ready),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .res_valid    (res_valid),
    .res_pass     (res_pass),
    .res_count    (res_count),
    .res_err_idx  (res_err_idx),
    .res_err_data (res_err_data),
    .res_ready    (res_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_fib(input int n);
    for (int i = 0; i < n; i++)
      vec[i] = (i < 2) ? 32'(i) : vec[i-1] + vec[i-2];
  endtask

  // Command is accepted on the first edge, since the checker is idle here.
  task automatic send_cmd(input string tag, input int len);
    chk({tag, "_cmd_rdy"}, {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1;
    cmd_len   = 8'(len);
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_cmd_rdy_lo"}, {31'd0, cmd_ready}, 0);
    if (len == 0) begin
      chk({tag, "_z_res_valid"}, {31'd0, res_valid}, 1);
      chk({tag, "_z_in_ready"}, {31'd0, in_ready}, 0);
    end else begin
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 1);
    end
  endtask

  task automatic send_beats(input string tag, input int n, input bit gap);
    logic hs;
    int   t;
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        in_valid = 1'b0;
        tick();
        chk({tag, "_bubble_res"}, {31'd0, res_valid}, 0);
      end
      in_valid = 1'b1;
      in_data  = vec[i];
      t  = 0;
      hs = 1'b0;
      while (!hs && t < 20) begin
        hs = in_ready;
        tick();
        t++;
      end
      if (!hs) chk({tag, "_beat_timeout"}, 32'(i), 32'hFFFF_FFFF);
    end
    in_valid = 1'b0;
    chk({tag, "_res_latency"}, {31'd0, res_valid}, 1);
  endtask

  task automatic get_result(input string tag, input logic exp_pass, input int exp_cnt,
                            input int exp_idx, input logic [31:0] exp_data, input int stall);
    int t;
    t = 0;
    while (!res_valid && t < 50) begin
      tick();
      t++;
    end
    chk({tag, "_res_valid"}, {31'd0, res_valid}, 1);
    chk({tag, "_pass"}, {31'd0, res_pass}, {31'd0, exp_pass});
    chk({tag, "_count"}, {24'd0, res_count}, 32'(exp_cnt));
    chk({tag, "_err_idx"}, {24'd0, res_err_idx}, 32'(exp_idx));
    chk({tag, "_err_data"}, res_err_data, exp_data);
    if (stall > 0) begin
      cmd_valid = 1'b1;
      cmd_len   = 8'd7;
      in_valid  = 1'b1;
      for (int i = 0; i < stall; i++) begin
        tick();
        chk({tag, "_stall_valid"}, {31'd0, res_valid}, 1);
        chk({tag, "_stall_cmd_rdy"}, {31'd0, cmd_ready}, 0);
        chk({tag, "_stall_in_rdy"}, {31'd0, in_ready}, 0);
        chk({tag, "_stall_pass"}, {31'd0, res_pass}, {31'd0, exp_pass});
        chk({tag, "_stall_count"}, {24'd0, res_count}, 32'(exp_cnt));
        chk({tag, "_stall_err_data"}, res_err_data, exp_data);
      end
      cmd_valid = 1'b0;
      in_valid  = 1'b0;
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_post_cmd_rdy"}, {31'd0, cmd_ready}, 1);
    chk({tag, "_post_res_valid"}, {31'd0, res_valid}, 0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_res_fields", {res_pass, res_count, res_err_idx, 15'd0}, 32'd0);
    chk("rst_res_data", res_err_data, 32'd0);
    rst = 1'b0;
    tick();

    // Basic pass
    vec[0] = 0; vec[1] = 1; vec[2] = 1; vec[3] = 2; vec[4] = 3;
    send_cmd("basic", 5);
    send_beats("basic", 5, 1'b0);
    get_result("basic", 1'b1, 5, 0, 32'd0, 0);

    // Single error at index 4
    vec[0] = 0; vec[1] = 1; vec[2] = 1; vec[3] = 2; vec[4] = 4; vec[5] = 5;
    send_cmd("err1", 6);
    send_beats("err1", 6, 1'b0);
    get_result("err1", 1'b0, 6, 4, 32'd4, 0);

    // Several errors: only the first (index 1) is reported
    vec[0] = 0; vec[1] = 7; vec[2] = 9; vec[3] = 2;
    send_cmd("multi", 4);
    send_beats("multi", 4, 1'b0);
    get_result("multi", 1'b0, 4, 1, 32'd7, 0);

    // Zero length
    send_cmd("zero", 0);
    get_result("zero", 1'b1, 0, 0, 32'd0, 0);

    // Bubbles, then result held off for 10 cycles
    vec[0] = 0; vec[1] = 1; vec[2] = 1; vec[3] = 2;
    send_cmd("bubble", 4);
    send_beats("bubble", 4, 1'b1);
    get_result("bubble", 1'b1, 4, 0, 32'd0, 10);

    // Error on the very last beat, result held off
    vec[0] = 0; vec[1] = 1; vec[2] = 5;
    send_cmd("lasterr", 3);
    send_beats("lasterr", 3, 1'b0);
    get_result("lasterr", 1'b0, 3, 2, 32'd5, 3);

    // Wrap-around: fib(48) mod 2^32 = 512559680
    fill_fib(50);
    vec[48] = 32'd512559680;
    send_cmd("wrap", 50);
    send_beats("wrap", 50, 1'b0);
    get_result("wrap", 1'b1, 50, 0, 32'd0, 0);

    // fib(49) mod 2^32 = 3483774753; corrupt it
    vec[49] = 32'd3483774754;
    send_cmd("wrap_err", 50);
    send_beats("wrap_err", 50, 1'b0);
    get_result("wrap_err", 1'b0, 50, 49, 32'd3483774754, 0);

    // Reset mid-job
    vec[0] = 0; vec[1] = 1; vec[2] = 1;
    send_cmd("midrst", 8);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("midrst_in_ready", {31'd0, in_ready}, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_res", {31'd0, res_valid}, 0);
    end
    send_cmd("after_rst", 3);
    send_beats("after_rst", 3, 1'b0);
    get_result("after_rst", 1'b1, 3, 0, 32'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fibonacci_checker
`default_nettype wire
